// File: rtl/imem_if.sv
// Program-memory read port of the cpuy instruction sequencer: a req/ack read
// handshake where ack may arrive in the same cycle as req.
interface imem_if #(
  parameter int PC_WIDTH = 8
);
  logic                req;
  logic [PC_WIDTH-1:0] addr;
  logic                ack;
  logic [7:0]          data;

  modport master (output req, addr, input ack, data);
  modport slave  (input req, addr, output ack, data);
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the cpuy core: owns the PC, fetches opcodes and
// jump operands over imem, and turns ucode flags into one-cycle strobes. Option macro: SEQ_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int                  PC_WIDTH     = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic       step,
`endif
  imem_if.master     imem,
  output logic [7:0] opcode,
  input  logic       alu_operation,
  input  logic       alu_multibyte_result,
  input  logic       jump_operation,
  input  logic       jump_condition,
  input  logic       mov_operation,
  input  logic       destination_w,
  input  logic       destination_flags,
  input  logic       destination_memory,
  input  logic       destination_registers,
  input  logic       destination_ports,
  output logic       alu_en,
  output logic       w_we,
  output logic       flags_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic       port_we,
  output logic       wb_hi,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_HALT, S_FETCH, S_DECODE, S_OPERAND, S_EXEC, S_WB, S_WB_HI
  } state_t;

  state_t              state, state_nxt, boundary_nxt;
  logic [PC_WIDTH-1:0] pc, pc_inc;
  logic                start;
  logic                wb_phase;
  logic                unused_inputs;

`ifdef SEQ_SINGLE_STEP_EN
  // A step pulse leaves HALT just like run; with run still low the
  // instruction boundary sends the sequencer straight back to HALT.
  assign start = run | step;
`else
  assign start = run;
`endif

  assign pc_inc        = pc + PC_WIDTH'(1);
  assign imem.addr     = pc;
  assign halted        = (state == S_HALT);
  assign unused_inputs = mov_operation ^ (^imem.data);

  // NOTE: state-holding processes use non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HALT;
    else     state <= state_nxt;
  end

  // Ack is only honoured in the two states that actually issue a request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_VECTOR;
      opcode <= 8'h00;
    end else if (state == S_FETCH && imem.ack) begin
      opcode <= imem.data;
      pc     <= pc_inc;
    end else if (state == S_OPERAND && imem.ack) begin
      pc     <= jump_condition ? imem.data[PC_WIDTH-1:0] : pc_inc;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    boundary_nxt = run ? S_FETCH : S_HALT;
    imem.req     = 1'b0;
    alu_en       = 1'b0;
    wb_phase     = 1'b0;
    wb_hi        = 1'b0;
    unique case (state)
      S_HALT:    if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        imem.req = 1'b1;
        if (imem.ack) state_nxt = S_DECODE;
      end
      S_DECODE:  state_nxt = jump_operation ? S_OPERAND : S_EXEC;
      S_OPERAND: begin
        imem.req = 1'b1;
        if (imem.ack) state_nxt = boundary_nxt;
      end
      S_EXEC: begin
        alu_en    = alu_operation;
        state_nxt = S_WB;
      end
      S_WB: begin
        wb_phase  = 1'b1;
        state_nxt = (alu_operation && alu_multibyte_result) ? S_WB_HI : boundary_nxt;
      end
      S_WB_HI: begin
        wb_phase  = 1'b1;
        wb_hi     = 1'b1;
        state_nxt = boundary_nxt;
      end
      default:   state_nxt = S_HALT;
    endcase
  end

  assign w_we     = wb_phase & destination_w;
  assign flags_we = wb_phase & destination_flags;
  assign mem_we   = wb_phase & destination_memory;
  assign reg_we   = wb_phase & destination_registers;
  assign port_we  = wb_phase & destination_ports;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, hand-written
// corner sequences and randomized programs against an instruction-level model.
module tb_instr_sequencer;
  localparam int PW = 8;

  typedef struct {
    logic [7:0] pc, op, operand;
    int         delay, cycles;
    logic [7:0] exp_pc;
    int         n_ev, ev0, ev1, ev2;   // (busy cycle index << 8) | strobe vector
  } vec_t;

  logic clk = 1'b0;
  logic rst, run;
`ifdef SEQ_SINGLE_STEP_EN
  logic step;
`endif
  logic [7:0] opcode;
  logic alu_operation, alu_multibyte_result, jump_operation, jump_condition, mov_operation;
  logic destination_w, destination_flags, destination_memory, destination_registers, destination_ports;
  logic alu_en, w_we, flags_we, mem_we, reg_we, port_we, wb_hi, halted;

  imem_if #(.PC_WIDTH(PW)) imem ();

  always #5 clk = ~clk;

  instr_sequencer #(.PC_WIDTH(PW), .RESET_VECTOR(8'h00)) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .imem(imem), .opcode(opcode),
    .alu_operation(alu_operation), .alu_multibyte_result(alu_multibyte_result),
    .jump_operation(jump_operation), .jump_condition(jump_condition), .mov_operation(mov_operation),
    .destination_w(destination_w), .destination_flags(destination_flags),
    .destination_memory(destination_memory), .destination_registers(destination_registers),
    .destination_ports(destination_ports),
    .alu_en(alu_en), .w_we(w_we), .flags_we(flags_we), .mem_we(mem_we), .reg_we(reg_we),
    .port_we(port_we), .wb_hi(wb_hi), .halted(halted)
  );

  // Stand-in ucode decoder: bit7 alu, bit6 multibyte, bit5 jump, bit4 condition, bits4:0 destinations.
  always_comb begin
    alu_operation         = opcode[7];
    alu_multibyte_result  = opcode[6];
    jump_operation        = opcode[5];
    jump_condition        = opcode[4];
    mov_operation         = ~opcode[7] & (|opcode[4:0]);
    destination_w         = opcode[4];
    destination_flags     = opcode[3];
    destination_memory    = opcode[2];
    destination_registers = opcode[1];
    destination_ports     = opcode[0];
  end

  // Program memory slave with programmable wait states plus activity monitor.
  logic [7:0] mem [256];
  logic       slave_ack = 1'b0, noise_ack = 1'b0, late_ack = 1'b0;
  bit         noise_en = 1'b0, rand_delay = 1'b0, req_seen = 1'b0;
  int         fixed_delay = 0, cur_delay = 0, wait_cnt = 0, delay_sum = 0;
  int         busy_cycles = 0, req_cycles = 0, overlap_cnt = 0;
  logic [7:0] req_addr;
  logic [7:0] acc_q[$];
  int         ev_q[$];
  logic [7:0] exp_addr[$];
  int         exp_ev[$];
  int         errors = 0, checks = 0;
  logic [7:0] model_pc = 8'h00, exp_opcode = 8'h00;

  assign imem.ack = slave_ack | noise_ack | late_ack;

  function automatic int pick_delay();
    return rand_delay ? int'($urandom_range(0, 2)) : fixed_delay;
  endfunction

  always @(negedge clk) begin
    logic [6:0] sv;
    if (rst) begin
      slave_ack = 1'b0; noise_ack = 1'b0; wait_cnt = 0; req_seen = 1'b0;
      cur_delay = pick_delay();
    end else begin
      if (slave_ack) begin
        acc_q.push_back(req_addr);
        delay_sum += cur_delay;
        wait_cnt  = 0;
        cur_delay = pick_delay();
      end else if (req_seen) begin
        wait_cnt++;
      end
      req_seen  = imem.req;
      req_addr  = imem.addr;
      slave_ack = imem.req && (wait_cnt >= cur_delay);
      noise_ack = noise_en && !imem.req && ($urandom_range(0, 1) == 1);
      imem.data = slave_ack ? mem[imem.addr] : 8'($urandom);
      sv = {alu_en, w_we, flags_we, mem_we, reg_we, port_we, wb_hi};
      if (!halted) begin
        if (sv != 7'd0) ev_q.push_back((busy_cycles << 8) | int'(sv));
        busy_cycles++;
      end
      if (imem.req) begin
        req_cycles++;
        if (sv[6:1] != 6'd0) overlap_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic set_delay(input bit rnd, input int d);
    rand_delay = rnd; fixed_delay = d; cur_delay = pick_delay(); wait_cnt = 0;
  endtask

  task automatic clear_logs();
    acc_q.delete(); ev_q.delete();
    delay_sum = 0; busy_cycles = 0; req_cycles = 0;
  endtask

  task automatic wait_halt(input string tag);
    int guard = 0;
    while (!halted && guard < 100) begin @(negedge clk); #1; guard++; end
    if (!halted) timeout({tag, "_halt"});
  endtask

  // Runs until stop_after reads were accepted, then drops run and waits for HALT.
  task automatic run_until(input int stop_after, input string tag);
    int guard = 0;
    run = 1'b1;
    while (acc_q.size() < stop_after && guard < 3000) begin @(negedge clk); #1; guard++; end
    run = 1'b0;
    if (guard >= 3000) timeout({tag, "_reads"});
    wait_halt(tag);
  endtask

  // Instruction-level reference: read trace, strobe events and base cycle cost.
  task automatic model(input logic [7:0] start, input int n, output int stop_after,
                       output int base, output logic [7:0] end_pc, output logic [7:0] last_op);
    logic [7:0] pc, op;
    logic [4:0] dest;
    exp_addr.delete(); exp_ev.delete();
    pc = start; base = 0; stop_after = 0; last_op = exp_opcode;
    for (int i = 0; i < n; i++) begin
      stop_after = exp_addr.size() + 1;
      op = mem[pc]; exp_addr.push_back(pc); pc = pc + 8'd1;
      dest = op[4:0]; last_op = op;
      if (op[5]) begin
        exp_addr.push_back(pc);
        pc   = op[4] ? mem[pc] : pc + 8'd1;
        base += 3;
      end else begin
        base += 4;
        if (op[7]) exp_ev.push_back(32'h40);
        if (dest != 5'd0) exp_ev.push_back(int'({1'b0, dest, 1'b0}));
        if (op[7] && op[6]) begin
          base += 1;
          exp_ev.push_back(int'({1'b0, dest, 1'b1}));
        end
      end
    end
    end_pc = pc;
  endtask

  task automatic run_program(input int n, input string tag);
    int stop_after, base, bad;
    logic [7:0] end_pc, last_op;
    model(model_pc, n, stop_after, base, end_pc, last_op);
    clear_logs();
    run_until(stop_after, tag);
    check({tag, "_nreads"}, acc_q.size(), exp_addr.size());
    check({tag, "_nevents"}, ev_q.size(), exp_ev.size());
    bad = 0;
    foreach (exp_addr[i]) if (i >= acc_q.size() || acc_q[i] !== exp_addr[i]) bad++;
    foreach (exp_ev[i]) if (i >= ev_q.size() || (ev_q[i] & 255) != exp_ev[i]) bad++;
    check({tag, "_trace_mismatches"}, bad, 0);
    check({tag, "_cycles"}, busy_cycles, base + delay_sum);
    check({tag, "_pc"}, imem.addr, end_pc);
    check({tag, "_opcode"}, opcode, last_op);
    model_pc = end_pc; exp_opcode = last_op;
  endtask

  task automatic goto_pc(input logic [7:0] target);
    if (model_pc != target) begin
      set_delay(1'b0, 0);
      mem[model_pc] = 8'h30;
      mem[8'(model_pc + 8'd1)] = target;
      run_program(1, "goto");
    end
  endtask

  function automatic int evj(input vec_t r, input int j);
    case (j)
      0:       return r.ev0;
      1:       return r.ev1;
      default: return r.ev2;
    endcase
  endfunction

  vec_t tbl [11];

  initial begin
    //           pc     op     opnd   dly cyc  exp_pc n  ev0     ev1     ev2
    tbl[0]  = '{8'h00, 8'h90, 8'h00, 0,  4, 8'h01, 2, 'h240, 'h320, 0};     // ALU -> W
    tbl[1]  = '{8'h01, 8'hC2, 8'h00, 0,  5, 8'h02, 3, 'h240, 'h304, 'h405}; // multibyte -> REG
    tbl[2]  = '{8'h10, 8'h30, 8'h40, 0,  3, 8'h40, 0, 0, 0, 0};              // jump taken
    tbl[3]  = '{8'h10, 8'h20, 8'h40, 0,  3, 8'h12, 0, 0, 0, 0};              // jump not taken
    tbl[4]  = '{8'h12, 8'h00, 8'h00, 0,  4, 8'h13, 0, 0, 0, 0};              // NOP
    tbl[5]  = '{8'h13, 8'h5F, 8'h00, 0,  4, 8'h14, 1, 'h33E, 0, 0};          // all dests, no ALU
    tbl[6]  = '{8'h14, 8'h81, 8'h00, 3,  7, 8'h15, 2, 'h540, 'h602, 0};      // 3 wait states
    tbl[7]  = '{8'hFF, 8'h00, 8'h00, 0,  4, 8'h00, 0, 0, 0, 0};              // pc wrap
    tbl[8]  = '{8'h10, 8'h30, 8'h40, 2,  7, 8'h40, 0, 0, 0, 0};              // jump, 2 waits per read
    tbl[9]  = '{8'h20, 8'h40, 8'h00, 0,  4, 8'h21, 0, 0, 0, 0};              // multibyte w/o ALU
    tbl[10] = '{8'h21, 8'hC0, 8'h00, 0,  5, 8'h22, 2, 'h240, 'h401, 0};      // WB_HI, no dest

    foreach (mem[i]) mem[i] = 8'($urandom);
    rst = 1'b1; run = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;

    check("reset_halted", halted, 1'b1);
    check("reset_req", imem.req, 1'b0);
    check("reset_pc", imem.addr, 8'h00);
    check("reset_opcode", opcode, 8'h00);
    check("reset_strobes", {alu_en, w_we, flags_we, mem_we, reg_we, port_we, wb_hi}, 7'd0);

    for (int i = 0; i < 11; i++) begin
      goto_pc(tbl[i].pc);
      set_delay(1'b0, tbl[i].delay);
      mem[tbl[i].pc] = tbl[i].op;
      mem[8'(tbl[i].pc + 8'd1)] = tbl[i].operand;
      clear_logs();
      run_until(1, $sformatf("row%0d", i));
      check($sformatf("row%0d_cycles", i), busy_cycles, tbl[i].cycles);
      check($sformatf("row%0d_pc", i), imem.addr, tbl[i].exp_pc);
      check($sformatf("row%0d_nevents", i), ev_q.size(), tbl[i].n_ev);
      for (int j = 0; j < tbl[i].n_ev; j++)
        check($sformatf("row%0d_event%0d", i, j), (j < ev_q.size()) ? ev_q[j] : -1, evj(tbl[i], j));
      model_pc = tbl[i].exp_pc; exp_opcode = tbl[i].op;
    end

    // Wait states: request, address and opcode hold until the ack arrives.
    set_delay(1'b0, 3);
    mem[model_pc] = 8'h90;
    clear_logs();
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("wait_hold%0d", k), {imem.req, imem.addr, opcode}, {1'b1, model_pc, exp_opcode});
    end
    run = 1'b0;
    wait_halt("wait");
    check("wait_opcode", opcode, 8'h90);
    check("wait_pc", imem.addr, 8'(model_pc + 8'd1));
    check("wait_cycles", busy_cycles, 7);
    model_pc = model_pc + 8'd1; exp_opcode = 8'h90;

    // run dropped during EXEC: writeback still happens, then no more fetches.
    set_delay(1'b0, 0);
    mem[model_pc] = 8'h82;
    clear_logs();
    run = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    check("exec_alu_en", alu_en, 1'b1);
    run = 1'b0;
    wait_halt("exec_stop");
    check("exec_stop_nevents", ev_q.size(), 2);
    check("exec_stop_wb", (ev_q.size() > 1) ? ev_q[1] : -1, 'h304);
    req_cycles = 0;
    repeat (5) @(negedge clk);
    #1;
    check("exec_stop_no_req", req_cycles, 0);
    check("exec_stop_halted", halted, 1'b1);
    model_pc = model_pc + 8'd1; exp_opcode = 8'h82;

    // Reset in the middle of a stalled fetch, followed by a stray ack.
    set_delay(1'b0, 10);
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("rst_pre_req", imem.req, 1'b1);
    #2 rst = 1'b1;
    #1 check("rst_req_drop", imem.req, 1'b0);
    @(negedge clk); #1 run = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1 late_ack = 1'b0;
    check("late_ack_state", {halted, imem.req, imem.addr, opcode}, {1'b1, 1'b0, 8'h00, 8'h00});
    model_pc = 8'h00; exp_opcode = 8'h00;

    // Randomized programs with random wait states and stray acks.
    noise_en = 1'b1;
    set_delay(1'b1, 0);
    for (int k = 0; k < 4; k++) begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      run_program(15, $sformatf("rand%0d", k));
    end
    noise_en = 1'b0;
    check("req_strobe_overlap", overlap_cnt, 0);

`ifdef SEQ_SINGLE_STEP_EN
    set_delay(1'b0, 0);
    mem[model_pc] = 8'h90;
    clear_logs();
    step = 1'b1;
    @(negedge clk); #1 step = 1'b0;
    wait_halt("step");
    check("step_reads", acc_q.size(), 1);
    check("step_nevents", ev_q.size(), 2);
    check("step_wb", (ev_q.size() > 1) ? (ev_q[1] & 255) : -1, 'h20);
    check("step_pc", imem.addr, 8'(model_pc + 8'd1));
    repeat (3) @(negedge clk);
    #1 check("step_halted", halted, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
